// File: rtl/alu_result_accumulator.sv
// Saturating signed accumulator for the ALU result stream: sums a latched
// number of results and presents the total on a valid/ready output port.
module alu_result_accumulator #(
  parameter int IN_W  = 5,
  parameter int ACC_W = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  in_data,
  output logic             in_ready,
  output logic             sum_valid,
  output logic [ACC_W-1:0] sum_data,
  input  logic             sum_ready,
  output logic             sat,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } state_t;

  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] len_q;
  logic [ACC_W:0]   sum_ext;
  logic [ACC_W-1:0] acc_next;
  logic             ovf;
  logic             beat;
  logic             last_beat;

  // One guard bit: overflow shows up as disagreement between the top two bits.
  always_comb begin
    sum_ext  = {acc[ACC_W-1], acc} + {{(ACC_W+1-IN_W){in_data[IN_W-1]}}, in_data};
    ovf      = sum_ext[ACC_W] ^ sum_ext[ACC_W-1];
    acc_next = ovf ? (sum_ext[ACC_W] ? ACC_MIN : ACC_MAX) : sum_ext[ACC_W-1:0];
  end

  assign beat      = in_valid & in_ready;
  assign last_beat = (cnt == CNT_W'(len_q - 1'b1));
  assign sum_data  = acc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      len_q     <= '0;
      sat       <= 1'b0;
      in_ready  <= 1'b0;
      sum_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            len_q <= len;
            acc   <= '0;
            cnt   <= '0;
            sat   <= 1'b0;
            busy  <= 1'b1;
            if (len == '0) begin
              state     <= DONE;
              sum_valid <= 1'b1;
            end else begin
              state    <= ACCUM;
              in_ready <= 1'b1;
            end
          end
        end
        ACCUM: begin
          if (beat) begin
            acc <= acc_next;
            cnt <= cnt + 1'b1;
            if (ovf) sat <= 1'b1;
            if (last_beat) begin
              state     <= DONE;
              in_ready  <= 1'b0;
              sum_valid <= 1'b1;
            end
          end
        end
        DONE: begin
          if (sum_ready) begin
            state     <= IDLE;
            sum_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b0;
          sum_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
